alu_share_ctrl: RTL and testbench
=================================

# alu_share_ctrl

Arbitrating sequencer that shares the single combinational 64-bit ALU between two requesters, e.g. the integer execute path (port 0) and the address/branch-compare path (port 1). It accepts one operation at a time through a valid/ready handshake and grants round-robin. It drives the ALU operands and `ALUcontrol` from registers, captures the result and the zero/negative/carry flags, and returns them tagged with the requester id.

## Interface
Parameters:
- `WIDTH`, 64, operand/result width; must match the ALU.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  requester has an operation pending.
- `req0_ready` / `req1_ready`  out  1  controller accepts this cycle; transfer = valid & ready.
- `req0_op` / `req1_op`  in  4  ALU control code.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  WIDTH  operands.
- `alu_a`, `alu_b`  out  WIDTH  registered operands to the ALU.
- `alu_ctrl`  out  4  registered `ALUcontrol` to the ALU.
- `alu_result`  in  WIDTH  ALU result.
- `alu_zero`, `alu_negative`  in  1  ALU flags.
- `alu_carry`  in  2  ALU carry; only bit 0 is used.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer takes the response; transfer = valid & ready.
- `rsp_id`  out  1  requester that issued the operation.
- `rsp_result`  out  WIDTH  captured result.
- `rsp_zero`, `rsp_negative`, `rsp_carry`  out  1  captured flags.
- `rsp_err`  out  1  illegal opcode.

## Operation
- Legal opcodes: `0000` AND, `0001` OR, `0010` ADD, `0110` SUB, `0111` EOR. All other codes are illegal.
- FSM states are IDLE, EXEC and RESP.
- **IDLE**
  - Grant: if both requests are valid, grant the port not granted last. If only one is valid, grant it.
  - `reqN_ready` is 1 only in IDLE, only for the granted port, and is combinational from valid and the last-grant register. Never both at once.
  - On transfer: latch op/a/b into `alu_ctrl`/`alu_a`/`alu_b`, latch the port into `rsp_id`, and update last-grant.
  - If the op is legal, next state is EXEC.
  - If the op is illegal, next state is RESP with `rsp_err`=1, `rsp_result`=0 and all flags 0. The ALU outputs are ignored.
- **EXEC** (exactly 1 cycle)
  - The ALU sees stable registered inputs.
  - Capture `alu_result` to `rsp_result`, `alu_zero` to `rsp_zero` and `alu_negative` to `rsp_negative`.
  - `rsp_carry` = `alu_carry[0]` for ADD/SUB; forced to 0 for AND/OR/EOR.
  - Set `rsp_err`=0. Next state is RESP.
- **RESP**
  - `rsp_valid`=1. All `rsp_*` outputs are held stable until `rsp_ready`.
  - On `rsp_ready`: next state is IDLE and `rsp_valid` drops the next cycle.
  - No new request is accepted in RESP.
- `alu_a`/`alu_b`/`alu_ctrl` hold their last latched values outside EXEC.
- Requests that are not granted keep waiting; requester inputs must stay stable while valid and not ready.

## Timing
- Reset (any state, including mid-operation):
  - State goes to IDLE and any in-flight operation is dropped with no response.
  - Last-grant is set to port 1, so port 0 wins the first tie.
  - All outputs are 0: `rsp_*`, `alu_a`, `alu_b`, `alu_ctrl`.
  - `reqN_ready`=0 while `reset`=1.
- Latency for a legal op accepted at cycle T: EXEC at T+1, `rsp_valid`=1 from T+2.
- Latency for an illegal op accepted at T: `rsp_valid`=1 from T+1.
- `rsp_ready` may be high already in the first RESP cycle. The response then completes in one cycle, IDLE is at T+3, and the next accept is possible at T+3.
- Peak throughput is 1 op per 3 cycles; illegal ops take 2.
- Response back-pressure stalls the controller indefinitely with no loss.
- Round-robin guarantees that a continuously valid requester is served within 2 grants.

## Test plan
- **Single ADD:** reset, then port 0 sends `0010` with a=5, b=7. Required: accept at T, `alu_ctrl`=`0010` at T+1, `rsp_valid` at T+2 with `rsp_result`=12, zero=0, carry=0, `rsp_id`=0, `rsp_err`=0.
- **SUB to zero and logic carry masking:**
  - Port 1 SUB with a=b=0x1234. Required: `rsp_result`=0, `rsp_zero`=1, `rsp_id`=1.
  - Port 1 AND with the ALU model driving carry=1. Required: `rsp_carry`=0.
- **Round-robin:** both ports continuously valid for 4 ops with `rsp_ready`=1. Required: grant order 0,1,0,1; a new accept every 3 cycles; `req0_ready` and `req1_ready` never high together.
- **Back-pressure:** hold `rsp_ready`=0 for 5 cycles after `rsp_valid`. Required: all `rsp_*` outputs stable; both `reqN_ready`=0. Raise `rsp_ready`: IDLE on the next cycle and the pending request is accepted.
- **Illegal opcode:** port 0 sends op=`0011`. Required: `rsp_valid` at T+1 with `rsp_err`=1, result 0, flags 0; `alu_ctrl` never enters EXEC.
- **Reset mid-operation:** assert `reset` during EXEC. Required: next cycle is IDLE with all outputs 0 and no response emitted. With both ports then valid, port 0 is granted first.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer sharing one combinational ALU between two requesters.
// Operands and control are registered toward the ALU; results return tagged with the requester id.
module alu_share_ctrl #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_negative,
    input  logic [1:0]       alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_negative,
    output logic             rsp_carry,
    output logic             rsp_err
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_t;

    localparam logic [3:0] OpAnd = 4'b0000;
    localparam logic [3:0] OpOr  = 4'b0001;
    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpSub = 4'b0110;
    localparam logic [3:0] OpEor = 4'b0111;

    state_t           state_q;
    logic             last_q;   // 1 when port 1 was granted last
    logic             gnt1;
    logic             take;
    logic [3:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             unused_carry_hi;

    assign unused_carry_hi = alu_carry[1];

    function automatic logic op_legal(input logic [3:0] op);
        return (op == OpAnd) || (op == OpOr) || (op == OpAdd) || (op == OpSub) || (op == OpEor);
    endfunction

    always_comb begin
        gnt1       = req1_valid && (!req0_valid || !last_q);
        req0_ready = !reset && (state_q == StIdle) && req0_valid && !gnt1;
        req1_ready = !reset && (state_q == StIdle) && gnt1;
        take       = req0_ready || req1_ready;
        sel_op     = gnt1 ? req1_op : req0_op;
        sel_a      = gnt1 ? req1_a  : req0_a;
        sel_b      = gnt1 ? req1_b  : req0_b;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_q       <= 1'b1;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_ctrl     <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_negative <= 1'b0;
            rsp_carry    <= 1'b0;
            rsp_err      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (take) begin
                        alu_ctrl <= sel_op;
                        alu_a    <= sel_a;
                        alu_b    <= sel_b;
                        rsp_id   <= gnt1;
                        last_q   <= gnt1;
                        if (op_legal(sel_op)) begin
                            state_q <= StExec;
                        end else begin
                            // Illegal ops bypass the ALU and answer straight away.
                            state_q      <= StResp;
                            rsp_valid    <= 1'b1;
                            rsp_err      <= 1'b1;
                            rsp_result   <= '0;
                            rsp_zero     <= 1'b0;
                            rsp_negative <= 1'b0;
                            rsp_carry    <= 1'b0;
                        end
                    end
                end
                StExec: begin
                    rsp_result   <= alu_result;
                    rsp_zero     <= alu_zero;
                    rsp_negative <= alu_negative;
                    rsp_carry    <= ((alu_ctrl == OpAdd) || (alu_ctrl == OpSub)) && alu_carry[0];
                    rsp_err      <= 1'b0;
                    rsp_valid    <= 1'b1;
                    state_q      <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: behavioural ALU stub, scoreboard model of expected responses,
// directed scenarios followed by a randomized phase.
module tb_alu_share_ctrl;
    localparam int unsigned W = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [3:0]   req0_op = '0, req1_op = '0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [3:0]   alu_ctrl;
    logic         alu_zero, alu_negative;
    logic [1:0]   alu_carry;
    logic         rsp_valid, rsp_id, rsp_zero, rsp_negative, rsp_carry, rsp_err;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_result;

    alu_share_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_negative(alu_negative),
        .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_negative(rsp_negative),
        .rsp_carry(rsp_carry), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU stub: logic ops and illegal codes drive garbage carry/result the controller must mask.
    always_comb begin
        alu_carry  = 2'b11;
        alu_result = '1;
        case (alu_ctrl)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0111: alu_result = alu_a ^ alu_b;
            4'b0010: {alu_carry[0], alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            4'b0110: {alu_carry[0], alu_result} = {1'b0, alu_a} + {1'b0, ~alu_b} + 65'd1;
            default: ;
        endcase
        alu_zero     = (alu_result == '0);
        alu_negative = alu_result[W-1];
    end

    typedef struct {
        logic         id;
        logic [3:0]   op;
        logic [W-1:0] a, b, res;
        logic         z, n, c, err;
        int           acc;
    } txn_t;

    txn_t sb[$];
    int   grants[$];
    int   acc_cyc[$];
    int   passes = 0, checks = 0;
    logic acc0, acc1, exec_pending = 1'b0, in_resp = 1'b0;
    txn_t exec_t;

    function automatic txn_t predict(input logic id, input logic [3:0] op,
                                     input logic [W-1:0] a, input logic [W-1:0] b);
        txn_t t;
        t.id = id; t.op = op; t.a = a; t.b = b; t.c = 1'b0; t.err = 1'b0; t.acc = 0;
        case (op)
            4'b0000: t.res = a & b;
            4'b0001: t.res = a | b;
            4'b0111: t.res = a ^ b;
            4'b0010: begin t.res = a + b; t.c = (t.res < a); end
            4'b0110: begin t.res = a - b; t.c = (a >= b); end
            default: begin t.res = '0; t.err = 1'b1; end
        endcase
        t.z = !t.err && (t.res == '0);
        t.n = !t.err && t.res[W-1];
        return t;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: observed %b expected %b", tag, got, exp);
    endtask

    function automatic logic [W-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [3:0] rand_legal();
        logic [3:0] ops [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111};
        return ops[$urandom_range(0, 4)];
    endfunction

    function automatic logic [3:0] rand_any();
        if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 15));
        return rand_legal();
    endfunction

    task automatic set_req(input int p, input logic v, input logic [3:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        if (p == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    task automatic accept(input logic p, input logic [3:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        txn_t t;
        t = predict(p, op, a, b);
        t.acc = cyc;
        sb.push_back(t);
        grants.push_back(int'(p));
        acc_cyc.push_back(cyc);
        if (!t.err) begin
            exec_pending = 1'b1;
            exec_t = t;
        end
    endtask

    // One clock: observe at the falling edge, return just after the rising edge.
    task automatic tick();
        txn_t t;
        acc0 = 1'b0;
        acc1 = 1'b0;
        @(negedge clk);
        if (!reset) begin
            chk1("ready_mutex", req0_ready & req1_ready, 1'b0);
            if (exec_pending) begin
                chk1("exec_no_rsp", rsp_valid, 1'b0);
                chk("exec_ctrl", 64'(alu_ctrl), 64'(exec_t.op));
                chk("exec_a", alu_a, exec_t.a);
                chk("exec_b", alu_b, exec_t.b);
                exec_pending = 1'b0;
            end
            if (rsp_valid) begin
                chk1("resp_blocks_req", req0_ready | req1_ready, 1'b0);
                if (sb.size() == 0) begin
                    chk1("rsp_unexpected", rsp_valid, 1'b0);
                end else begin
                    t = sb[0];
                    if (!in_resp)
                        chk("rsp_latency", 64'(cyc - t.acc), t.err ? 64'd1 : 64'd2);
                    chk1("rsp_id", rsp_id, t.id);
                    chk("rsp_result", rsp_result, t.res);
                    chk1("rsp_zero", rsp_zero, t.z);
                    chk1("rsp_negative", rsp_negative, t.n);
                    chk1("rsp_carry", rsp_carry, t.c);
                    chk1("rsp_err", rsp_err, t.err);
                    in_resp = !rsp_ready;
                    if (rsp_ready) void'(sb.pop_front());
                end
            end
            if (req0_valid && req0_ready) begin accept(1'b0, req0_op, req0_a, req0_b); acc0 = 1'b1; end
            if (req1_valid && req1_ready) begin accept(1'b1, req1_op, req1_a, req1_b); acc1 = 1'b1; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        chk("drain_empty", 64'(sb.size()), 64'd0);
        tick();
    endtask

    task automatic run_op(input int p, input logic [3:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        logic got = 1'b0;
        set_req(p, 1'b1, op, a, b);
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            got = (p == 0) ? acc0 : acc1;
        end
        chk1("accept_seen", got, 1'b1);
        set_req(p, 1'b0, op, a, b);
        drain();
    endtask

    int base;
    int n;
    logic got;

    initial begin
        // Reset with both requesters valid: nothing granted, all outputs zero.
        set_req(0, 1'b1, 4'b0010, rnd64(), rnd64());
        set_req(1, 1'b1, 4'b0010, rnd64(), rnd64());
        repeat (2) @(posedge clk);
        #2;
        chk1("rst_ready0", req0_ready, 1'b0);
        chk1("rst_ready1", req1_ready, 1'b0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_result", rsp_result, '0);
        chk("rst_alu_a", alu_a, '0);
        chk("rst_alu_b", alu_b, '0);
        chk("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
        chk("rst_flags", 64'({rsp_id, rsp_zero, rsp_negative, rsp_carry, rsp_err}), 64'd0);
        set_req(0, 1'b0, 4'b0000, '0, '0);
        set_req(1, 1'b0, 4'b0000, '0, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        rsp_ready = 1'b1;

        // Single ADD, SUB to zero, AND with stub carry forced high.
        run_op(0, 4'b0010, 64'd5, 64'd7);
        run_op(1, 4'b0110, 64'h1234, 64'h1234);
        run_op(1, 4'b0000, rnd64(), rnd64());

        // Round-robin with both ports continuously valid; port 1 was granted last.
        base = grants.size();
        set_req(0, 1'b1, rand_legal(), rnd64(), rnd64());
        set_req(1, 1'b1, rand_legal(), rnd64(), rnd64());
        for (int i = 0; i < 40 && grants.size() < base + 4; i++) begin
            tick();
            if (acc0) set_req(0, 1'b1, rand_legal(), rnd64(), rnd64());
            if (acc1) set_req(1, 1'b1, rand_legal(), rnd64(), rnd64());
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n = grants.size() - base;
        chk("rr_count", 64'(n), 64'd4);
        for (int k = 0; k < n && k < 4; k++) chk("rr_order", 64'(grants[base+k]), 64'(k % 2));
        for (int k = 1; k < n && k < 4; k++)
            chk("rr_spacing", 64'(acc_cyc[base+k] - acc_cyc[base+k-1]), 64'd3);
        drain();

        // Back-pressure: response held 5 extra cycles while port 1 waits.
        rsp_ready = 1'b0;
        got = 1'b0;
        set_req(0, 1'b1, rand_legal(), rnd64(), rnd64());
        for (int i = 0; i < 10 && !got; i++) begin tick(); got = acc0; end
        chk1("bp_accept0", got, 1'b1);
        req0_valid = 1'b0;
        set_req(1, 1'b1, rand_legal(), rnd64(), rnd64());
        for (int i = 0; i < 10 && !rsp_valid; i++) tick();
        chk1("bp_rsp_valid", rsp_valid, 1'b1);
        repeat (5) tick();
        rsp_ready = 1'b1;
        tick();
        tick();
        chk1("bp_next_accept", acc1, 1'b1);
        req1_valid = 1'b0;
        drain();

        // Illegal opcode.
        run_op(0, 4'b0011, rnd64(), rnd64());

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 300; i++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (!req0_valid && $urandom_range(0, 2) == 0) set_req(0, 1'b1, rand_any(), rnd64(), rnd64());
            if (!req1_valid && $urandom_range(0, 2) == 0) set_req(1, 1'b1, rand_any(), rnd64(), rnd64());
            tick();
            if (acc0) req0_valid = 1'b0;
            if (acc1) req1_valid = 1'b0;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

        // Reset during EXEC of a port-0 op: dropped, then port 0 wins the first tie.
        got = 1'b0;
        set_req(0, 1'b1, 4'b0010, rnd64(), rnd64());
        for (int i = 0; i < 10 && !got; i++) begin tick(); got = acc0; end
        chk1("mid_accept", got, 1'b1);
        req0_valid = 1'b0;
        reset = 1'b1;
        tick();
        sb.delete();
        exec_pending = 1'b0;
        in_resp = 1'b0;
        reset = 1'b0;
        set_req(0, 1'b1, rand_legal(), rnd64(), rnd64());
        set_req(1, 1'b1, rand_legal(), rnd64(), rnd64());
        #2;
        chk1("mid_rsp_valid", rsp_valid, 1'b0);
        chk("mid_rsp_result", rsp_result, '0);
        chk("mid_alu_a", alu_a, '0);
        chk("mid_alu_b", alu_b, '0);
        chk("mid_alu_ctrl", 64'(alu_ctrl), 64'd0);
        chk("mid_flags", 64'({rsp_id, rsp_zero, rsp_negative, rsp_carry, rsp_err}), 64'd0);
        chk1("mid_ready0", req0_ready, 1'b1);
        chk1("mid_ready1", req1_ready, 1'b0);
        tick();
        chk1("mid_first_grant0", acc0, 1'b1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
